// File: rtl/multicycle_sequencer_if.sv
//------------------------------------------------------------------------------
// Module  : multicycle_sequencer_if
// Brief   : Shared memory-port handshake between the sequencer and memory.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface multicycle_sequencer_if;
   logic mem_req;
   logic IorD;
   logic MemRead;
   logic MemWrite;
   logic mem_ready;

   modport master (
      output mem_req,
      output IorD,
      output MemRead,
      output MemWrite,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  IorD,
      input  MemRead,
      input  MemWrite,
      output mem_ready
   );
endinterface

`default_nettype wire

// File: rtl/multicycle_sequencer.sv
//------------------------------------------------------------------------------
// Module  : multicycle_sequencer
// Brief   : Multi-cycle MIPS-subset control FSM driving datapath enables.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_sequencer #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 16
) (
   input  wire logic                 i_clk,
   input  wire logic                 i_rst_n,
   input  wire logic                 i_run,
   input  wire logic [5:0]           i_opcode,
   multicycle_sequencer_if.master    mem,
   output logic                      o_IRWrite,
   output logic                      o_PCWrite,
   output logic                      o_PCWriteCond,
   output logic                      o_Bne,
   output logic [1:0]                o_PCSource,
   output logic                      o_ALUSrcA,
   output logic [1:0]                o_ALUSrcB,
   output logic [1:0]                o_ALUOp,
   output logic                      o_RegDst,
   output logic                      o_MemtoReg,
   output logic                      o_RegWrite,
   output logic                      o_retire,
   output logic [CNT_W-1:0]          o_retired_count,
   output logic [3:0]                o_state,
   output logic                      o_illegal,
   output logic                      o_fault
);

   localparam int               WAIT_W  = 16;
   localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      FETCH    = 4'd1,
      DECODE   = 4'd2,
      EXEC_R   = 4'd3,
      R_WB     = 4'd4,
      EXEC_I   = 4'd5,
      I_WB     = 4'd6,
      MEM_ADDR = 4'd7,
      MEM_RD   = 4'd8,
      MEM_WB   = 4'd9,
      MEM_WR   = 4'd10,
      BRANCH   = 4'd11,
      JUMP     = 4'd12,
      ILLEGAL  = 4'd13,
      FAULT    = 4'd14
   } state_t;

   state_t              state_q, state_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                complete;
   logic                timeout;
   logic                mem_req, iord, mem_read, mem_write;

   assign timeout = (wait_q == TO_LAST);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         wait_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      wait_d        = '0;
      complete      = 1'b0;
      mem_req       = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      o_IRWrite     = 1'b0;
      o_PCWrite     = 1'b0;
      o_PCWriteCond = 1'b0;
      o_Bne         = 1'b0;
      o_PCSource    = 2'b00;
      o_ALUSrcA     = 1'b0;
      o_ALUSrcB     = 2'b00;
      o_ALUOp       = 2'b00;
      o_RegDst      = 1'b0;
      o_MemtoReg    = 1'b0;
      o_RegWrite    = 1'b0;

      // Wait counter returns to zero whenever a wait state is left, so entry always starts clean.
      case (state_q)
         IDLE: begin
            if (i_run) state_d = FETCH;
         end
         FETCH: begin
            mem_req   = 1'b1;
            mem_read  = 1'b1;
            o_ALUSrcB = 2'b01;
            if (mem.mem_ready) begin
               o_IRWrite = 1'b1;
               o_PCWrite = 1'b1;
               state_d   = DECODE;
            end else if (timeout) begin
               state_d = FAULT;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         DECODE: begin
            o_ALUSrcB = 2'b11;
            case (i_opcode)
               OP_RTYPE:         state_d = EXEC_R;
               OP_ADDI, OP_ANDI: state_d = EXEC_I;
               OP_LW, OP_SW:     state_d = MEM_ADDR;
               OP_BEQ, OP_BNE:   state_d = BRANCH;
               OP_J:             state_d = JUMP;
               default:          state_d = ILLEGAL;
            endcase
         end
         EXEC_R: begin
            o_ALUSrcA = 1'b1;
            o_ALUOp   = 2'b10;
            state_d   = R_WB;
         end
         R_WB: begin
            o_RegDst   = 1'b1;
            o_RegWrite = 1'b1;
            complete   = 1'b1;
         end
         EXEC_I: begin
            o_ALUSrcA = 1'b1;
            o_ALUSrcB = 2'b10;
            o_ALUOp   = (i_opcode == OP_ANDI) ? 2'b11 : 2'b00;
            state_d   = I_WB;
         end
         I_WB: begin
            o_RegWrite = 1'b1;
            complete   = 1'b1;
         end
         MEM_ADDR: begin
            o_ALUSrcA = 1'b1;
            o_ALUSrcB = 2'b10;
            state_d   = (i_opcode == OP_LW) ? MEM_RD : MEM_WR;
         end
         MEM_RD: begin
            mem_req  = 1'b1;
            iord     = 1'b1;
            mem_read = 1'b1;
            if (mem.mem_ready)  state_d = MEM_WB;
            else if (timeout)   state_d = FAULT;
            else                wait_d  = wait_q + 1'b1;
         end
         MEM_WB: begin
            o_MemtoReg = 1'b1;
            o_RegWrite = 1'b1;
            complete   = 1'b1;
         end
         MEM_WR: begin
            mem_req   = 1'b1;
            iord      = 1'b1;
            mem_write = 1'b1;
            if (mem.mem_ready)  complete = 1'b1;
            else if (timeout)   state_d  = FAULT;
            else                wait_d   = wait_q + 1'b1;
         end
         BRANCH: begin
            o_ALUSrcA     = 1'b1;
            o_ALUOp       = 2'b01;
            o_PCWriteCond = 1'b1;
            o_PCSource    = 2'b01;
            o_Bne         = (i_opcode == OP_BNE);
            complete      = 1'b1;
         end
         JUMP: begin
            o_PCWrite  = 1'b1;
            o_PCSource = 2'b10;
            complete   = 1'b1;
         end
         ILLEGAL: state_d = ILLEGAL;
         FAULT:   state_d = FAULT;
         default: state_d = IDLE;
      endcase

      if (complete) state_d = i_run ? FETCH : IDLE;
   end

   assign count_d = count_q + CNT_W'(complete);

   assign mem.mem_req      = mem_req;
   assign mem.IorD         = iord;
   assign mem.MemRead      = mem_read;
   assign mem.MemWrite     = mem_write;
   assign o_retire         = complete;
   assign o_retired_count  = count_q;
   assign o_state          = state_q;
   // Both trap states are terminal, so the state itself holds the sticky flags.
   assign o_illegal        = (state_q == ILLEGAL);
   assign o_fault          = (state_q == FAULT);

endmodule

`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
//------------------------------------------------------------------------------
// Module  : tb_multicycle_sequencer
// Brief   : Directed self-checking bench for multicycle_sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_sequencer;

   localparam logic [20:0] MREQ     = 21'(1) << 20;
   localparam logic [20:0] IORD     = 21'(1) << 19;
   localparam logic [20:0] MRD      = 21'(1) << 18;
   localparam logic [20:0] MWR      = 21'(1) << 17;
   localparam logic [20:0] IRW      = 21'(1) << 16;
   localparam logic [20:0] PCW      = 21'(1) << 15;
   localparam logic [20:0] PCWC     = 21'(1) << 14;
   localparam logic [20:0] BNE      = 21'(1) << 13;
   localparam logic [20:0] PCS_OUT  = 21'(1) << 11;
   localparam logic [20:0] PCS_J    = 21'(2) << 11;
   localparam logic [20:0] SRCA     = 21'(1) << 10;
   localparam logic [20:0] SRCB_4   = 21'(1) << 8;
   localparam logic [20:0] SRCB_IMM = 21'(2) << 8;
   localparam logic [20:0] SRCB_SH  = 21'(3) << 8;
   localparam logic [20:0] OP_SUB   = 21'(1) << 6;
   localparam logic [20:0] OP_F     = 21'(2) << 6;
   localparam logic [20:0] OP_AND   = 21'(3) << 6;
   localparam logic [20:0] RDST     = 21'(1) << 5;
   localparam logic [20:0] M2R      = 21'(1) << 4;
   localparam logic [20:0] RW       = 21'(1) << 3;
   localparam logic [20:0] RET      = 21'(1) << 2;
   localparam logic [20:0] ILL      = 21'(1) << 1;
   localparam logic [20:0] FLT      = 21'(1);

   localparam logic [20:0] FETCH_W   = MREQ | MRD | SRCB_4;
   localparam logic [20:0] FETCH_RDY = FETCH_W | IRW | PCW;
   localparam logic [20:0] MEMRD_C   = MREQ | IORD | MRD;
   localparam logic [20:0] MEMWR_C   = MREQ | IORD | MWR;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic [5:0]  opcode;
   logic        IRWrite, PCWrite, PCWriteCond, Bne, ALUSrcA;
   logic        RegDst, MemtoReg, RegWrite, retire, illegal, fault;
   logic [1:0]  PCSource, ALUSrcB, ALUOp;
   logic [15:0] count;
   logic [3:0]  state;
   logic [20:0] ctl;

   int checks = 0;
   int errors = 0;

   multicycle_sequencer_if mif ();

   multicycle_sequencer #(
      .MEM_TIMEOUT (4),
      .CNT_W       (16)
   ) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_run           (run),
      .i_opcode        (opcode),
      .mem             (mif),
      .o_IRWrite       (IRWrite),
      .o_PCWrite       (PCWrite),
      .o_PCWriteCond   (PCWriteCond),
      .o_Bne           (Bne),
      .o_PCSource      (PCSource),
      .o_ALUSrcA       (ALUSrcA),
      .o_ALUSrcB       (ALUSrcB),
      .o_ALUOp         (ALUOp),
      .o_RegDst        (RegDst),
      .o_MemtoReg      (MemtoReg),
      .o_RegWrite      (RegWrite),
      .o_retire        (retire),
      .o_retired_count (count),
      .o_state         (state),
      .o_illegal       (illegal),
      .o_fault         (fault)
   );

   assign ctl = {mif.mem_req, mif.IorD, mif.MemRead, mif.MemWrite, IRWrite, PCWrite,
                 PCWriteCond, Bne, PCSource, ALUSrcA, ALUSrcB, ALUOp,
                 RegDst, MemtoReg, RegWrite, retire, illegal, fault};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs are set by the caller beforehand; sample, then advance one clock.
   task automatic cyc(input string tag, input logic [3:0] exp_state, input logic [20:0] exp_ctl);
      #1;
      check({tag, "_state"}, 32'(state), 32'(exp_state));
      check({tag, "_ctl"}, 32'(ctl), 32'(exp_ctl));
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse(input string tag);
      rst_n = 1'b0;
      #1;
      check({tag, "_state"}, 32'(state), 32'd0);
      check({tag, "_ctl"}, 32'(ctl), 32'd0);
      check({tag, "_cnt"}, 32'(count), 32'd0);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n         = 1'b0;
      run           = 1'b0;
      opcode        = 6'b000000;
      mif.mem_ready = 1'b1;
      #3;
      check("rst_state", 32'(state), 32'd0);
      check("rst_ctl", 32'(ctl), 32'd0);
      check("rst_cnt", 32'(count), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      cyc("idle_norun", 0, '0);
      run = 1'b1;
      cyc("idle_go", 0, '0);

      // R-type
      cyc("r_fetch", 1, FETCH_RDY);
      cyc("r_dec", 2, SRCB_SH);
      cyc("r_exec", 3, SRCA | OP_F);
      cyc("r_wb", 4, RDST | RW | RET);
      check("cnt_r", 32'(count), 32'd1);

      // lw, ready delayed 3 cycles in FETCH and MEM_RD (last wait hits the timeout boundary)
      opcode = 6'b100011;
      mif.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) cyc("lw_fwait", 1, FETCH_W);
      mif.mem_ready = 1'b1;
      cyc("lw_fetch", 1, FETCH_RDY);
      cyc("lw_dec", 2, SRCB_SH);
      cyc("lw_addr", 7, SRCA | SRCB_IMM);
      mif.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) cyc("lw_rdwait", 8, MEMRD_C);
      mif.mem_ready = 1'b1;
      cyc("lw_rd", 8, MEMRD_C);
      cyc("lw_wb", 9, M2R | RW | RET);
      check("cnt_lw", 32'(count), 32'd2);

      // sw with one wait cycle
      opcode = 6'b101011;
      cyc("sw_fetch", 1, FETCH_RDY);
      cyc("sw_dec", 2, SRCB_SH);
      cyc("sw_addr", 7, SRCA | SRCB_IMM);
      mif.mem_ready = 1'b0;
      cyc("sw_wait", 10, MEMWR_C);
      mif.mem_ready = 1'b1;
      cyc("sw_wr", 10, MEMWR_C | RET);
      check("cnt_sw", 32'(count), 32'd3);

      // bne, beq, j
      opcode = 6'b000101;
      cyc("bne_fetch", 1, FETCH_RDY);
      cyc("bne_dec", 2, SRCB_SH);
      cyc("bne", 11, SRCA | OP_SUB | PCWC | PCS_OUT | BNE | RET);
      opcode = 6'b000100;
      cyc("beq_fetch", 1, FETCH_RDY);
      cyc("beq_dec", 2, SRCB_SH);
      cyc("beq", 11, SRCA | OP_SUB | PCWC | PCS_OUT | RET);
      opcode = 6'b000010;
      cyc("j_fetch", 1, FETCH_RDY);
      cyc("j_dec", 2, SRCB_SH);
      cyc("j", 12, PCW | PCS_J | RET);
      check("cnt_j", 32'(count), 32'd6);

      // addi, then andi with run dropped mid-instruction
      opcode = 6'b001000;
      cyc("addi_fetch", 1, FETCH_RDY);
      cyc("addi_dec", 2, SRCB_SH);
      cyc("addi_ex", 5, SRCA | SRCB_IMM);
      cyc("addi_wb", 6, RW | RET);
      opcode = 6'b001100;
      cyc("andi_fetch", 1, FETCH_RDY);
      cyc("andi_dec", 2, SRCB_SH);
      run = 1'b0;
      cyc("andi_ex", 5, SRCA | SRCB_IMM | OP_AND);
      cyc("andi_wb", 6, RW | RET);
      cyc("andi_idle", 0, '0);
      check("cnt_andi", 32'(count), 32'd8);

      // reset while MEM_RD waits
      run    = 1'b1;
      opcode = 6'b100011;
      cyc("rd_idle", 0, '0);
      cyc("rd_fetch", 1, FETCH_RDY);
      cyc("rd_dec", 2, SRCB_SH);
      cyc("rd_addr", 7, SRCA | SRCB_IMM);
      mif.mem_ready = 1'b0;
      cyc("rd_wait", 8, MEMRD_C);
      reset_pulse("rst_memrd");

      // illegal opcode
      opcode = 6'b111111;
      mif.mem_ready = 1'b1;
      cyc("ill_idle", 0, '0);
      cyc("ill_fetch", 1, FETCH_RDY);
      cyc("ill_dec", 2, SRCB_SH);
      for (int i = 0; i < 3; i++) cyc("ill_hold", 13, ILL);
      check("cnt_ill", 32'(count), 32'd0);
      reset_pulse("rst_ill");

      // memory timeout in FETCH
      mif.mem_ready = 1'b0;
      cyc("to_idle", 0, '0);
      for (int i = 0; i < 4; i++) cyc("to_fwait", 1, FETCH_W);
      for (int i = 0; i < 2; i++) cyc("fault_hold", 14, FLT);
      reset_pulse("rst_fault");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
